// File: rtl/wash_sequencer.sv
// Washing-machine sequencer: fill/agitate/drain passes, final spin, abort drain.
// Optional PAUSE_EN adds a pause input that freezes the running program.
module wash_sequencer #(
   parameter int CNT_W       = 16,
   parameter int FILL_TICKS  = 8,
   parameter int WASH_TICKS  = 32,
   parameter int DIR_TICKS   = 6,
   parameter int REST_TICKS  = 2,
   parameter int DRAIN_TICKS = 8,
   parameter int SPIN_TICKS  = 16,
   parameter int NUM_RINSE   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
`ifdef PAUSE_EN
   input  logic       pause,
`endif
   input  logic [1:0] mode,
   output logic       ctrl_fill,
   output logic       ctrl_release,
   output logic       ctrl_forward,
   output logic       ctrl_reverse,
   output logic       busy,
   output logic       done,
   output logic [2:0] phase,
   output logic [2:0] pass_idx
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_WASH  = 3'd2,
      S_DRAIN = 3'd3,
      S_SPIN  = 3'd4,
      S_ABORT = 3'd5
   } state_e;

   localparam logic [1:0] M_NORMAL    = 2'd0;
   localparam logic [1:0] M_QUICK     = 2'd1;
   localparam logic [1:0] M_RINSE     = 2'd2;
   localparam logic [1:0] M_SPIN_ONLY = 2'd3;

   localparam int               PERIOD_I = 2 * DIR_TICKS + 2 * REST_TICKS;
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] PERIOD   = (PERIOD_I == 0) ? ONE : CNT_W'(PERIOD_I);
   localparam logic [CNT_W-1:0] FWD_END  = CNT_W'(DIR_TICKS);
   localparam logic [CNT_W-1:0] REV_BEG  = CNT_W'(DIR_TICKS + REST_TICKS);
   localparam logic [CNT_W-1:0] REV_END  = CNT_W'(2 * DIR_TICKS + REST_TICKS);
   localparam int               MAX_SKIP = 28;

   state_e           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [2:0]       pass_q, pass_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] sub_q, sub_d;
   logic             done_q, done_d;
   logic             pause_q, pause_d;
   logic             pause_in;

`ifdef PAUSE_EN
   assign pause_in = pause;
`else
   assign pause_in = 1'b0;
`endif

   function automatic logic [CNT_W-1:0] dur_of(input state_e s, input logic [1:0] m);
      logic [CNT_W-1:0] d;
      case (s)
         S_FILL:          d = CNT_W'(FILL_TICKS);
         S_WASH:          d = (m == M_QUICK) ? CNT_W'(WASH_TICKS >> 1) : CNT_W'(WASH_TICKS);
         S_DRAIN, S_ABORT: d = CNT_W'(DRAIN_TICKS);
         S_SPIN:          d = CNT_W'(SPIN_TICKS);
         default:         d = '0;
      endcase
      return d;
   endfunction

   function automatic logic [3:0] npass(input logic [1:0] m);
      logic [3:0] n;
      case (m)
         M_NORMAL: n = 4'(NUM_RINSE + 1);
         M_QUICK:  n = 4'd1;
         M_RINSE:  n = 4'(NUM_RINSE);
         default:  n = 4'd0;
      endcase
      return n;
   endfunction

   function automatic state_e first_of(input logic [1:0] m);
      state_e s;
      if (m == M_SPIN_ONLY)     s = S_DRAIN;
      else if (npass(m) == 4'd0) s = S_SPIN;
      else                      s = S_FILL;
      return s;
   endfunction

   // Program order: pass = FILL, WASH, DRAIN; last drain leads to SPIN, SPIN to IDLE.
   function automatic void succ(input state_e s, input logic [2:0] p, input logic [1:0] m,
                                output state_e ns, output logic [2:0] np);
      ns = S_IDLE;
      np = p;
      case (s)
         S_FILL:  ns = S_WASH;
         S_WASH:  ns = S_DRAIN;
         S_DRAIN: begin
            if (m != M_SPIN_ONLY && ({1'b0, p} + 4'd1) < npass(m)) begin
               ns = S_FILL;
               np = p + 3'd1;
            end else begin
               ns = S_SPIN;
            end
         end
         default: ns = S_IDLE;
      endcase
   endfunction

   logic [CNT_W-1:0] cur_dur;
   logic             expire;
   logic             live;
   logic             adv;
   state_e           tgt;
   logic [2:0]       tgt_pass;

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      pass_d   = pass_q;
      cnt_d    = cnt_q;
      sub_d    = sub_q;
      done_d   = 1'b0;
      adv      = 1'b0;
      tgt      = S_IDLE;
      tgt_pass = pass_q;
      cur_dur  = dur_of(state_q, mode_q);
      expire   = (cur_dur == '0) || (cnt_q >= cur_dur - ONE);
      live     = !pause_q || (state_q == S_ABORT);

      if (state_q == S_IDLE) begin
         if (start && !abort) begin
            mode_d   = mode;
            adv      = 1'b1;
            tgt      = first_of(mode);
            tgt_pass = '0;
         end
      end else if (abort && state_q != S_ABORT) begin
         cnt_d = '0;
         sub_d = '0;
         if (DRAIN_TICKS == 0) begin
            state_d = S_IDLE;
            pass_d  = '0;
         end else begin
            state_d = S_ABORT;
         end
      end else if (live) begin
         if (expire) begin
            if (state_q == S_ABORT) begin
               state_d = S_IDLE;
               pass_d  = '0;
               cnt_d   = '0;
               sub_d   = '0;
            end else begin
               adv = 1'b1;
               succ(state_q, pass_q, mode_q, tgt, tgt_pass);
            end
         end else begin
            cnt_d = cnt_q + ONE;
            sub_d = (sub_q >= PERIOD - ONE) ? '0 : sub_q + ONE;
         end
      end

      // Zero-length phases are stepped over within the same edge.
      if (adv) begin
         for (int i = 0; i < MAX_SKIP; i++) begin
            if (tgt != S_IDLE && dur_of(tgt, mode_d) == '0)
               succ(tgt, tgt_pass, mode_d, tgt, tgt_pass);
         end
         state_d = tgt;
         pass_d  = (tgt == S_IDLE) ? 3'd0 : tgt_pass;
         cnt_d   = '0;
         sub_d   = '0;
         done_d  = (tgt == S_IDLE);
      end

      pause_d = pause_in && (state_d inside {S_FILL, S_WASH, S_DRAIN, S_SPIN});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mode_q  <= '0;
         pass_q  <= '0;
         cnt_q   <= '0;
         sub_q   <= '0;
         done_q  <= 1'b0;
         pause_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         pass_q  <= pass_d;
         cnt_q   <= cnt_d;
         sub_q   <= sub_d;
         done_q  <= done_d;
         pause_q <= pause_d;
      end
   end

   // Motor lines come only from the wash pattern or spin, so they never overlap.
   always_comb begin
      ctrl_fill    = 1'b0;
      ctrl_release = 1'b0;
      ctrl_forward = 1'b0;
      ctrl_reverse = 1'b0;
      if (!pause_q) begin
         case (state_q)
            S_FILL:           ctrl_fill = 1'b1;
            S_WASH: begin
               ctrl_forward = (sub_q < FWD_END);
               ctrl_reverse = (sub_q >= REV_BEG) && (sub_q < REV_END);
            end
            S_DRAIN, S_ABORT: ctrl_release = 1'b1;
            S_SPIN: begin
               ctrl_release = 1'b1;
               ctrl_forward = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign phase    = state_q;
   assign pass_idx = pass_q;

endmodule

// File: doc/wash_sequencer.md
Name: wash_sequencer

Overview:
Parametrised successor to the fixed washing-machine register controller. It sequences fill, agitate, drain and spin phases with programmable durations and a programmable rinse count. A 2-bit program select chooses among four wash programs, and an abort input forces a safe drain. It sits between the front-panel start/abort/mode inputs and the valve and motor control lines.

Parameters:
CNT_W, 16, width of the phase tick counters
FILL_TICKS, 8, cycles the fill valve is open per pass
WASH_TICKS, 32, agitate cycles per pass (mode QUICK uses WASH_TICKS>>1)
DIR_TICKS, 6, motor on-time per direction during agitate
REST_TICKS, 2, motor-off gap between direction changes
DRAIN_TICKS, 8, cycles the drain valve is open per pass and for abort drain
SPIN_TICKS, 16, final spin cycles
NUM_RINSE, 1, rinse passes after the wash pass (0..7)

Ports:
clk  in  1  system clock (1 ms tick)
rst_n  in  1  asynchronous active-low reset
start  in  1  level; sampled only in IDLE
abort  in  1  level; sampled while busy
mode  in  2  program: 0 NORMAL, 1 QUICK, 2 RINSE_SPIN, 3 SPIN_ONLY; latched on start
ctrl_fill  out  1  fill valve
ctrl_release  out  1  drain valve
ctrl_forward  out  1  motor forward
ctrl_reverse  out  1  motor reverse
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when a program completes normally
phase  out  3  0 IDLE, 1 FILL, 2 WASH, 3 DRAIN, 4 SPIN, 5 ABORT
pass_idx  out  3  current pass index, 0 = first pass

Behaviour:
- Reset: async assert drives all outputs to 0, state to IDLE and counters to 0, including mid-program.
- All outputs are registered and decoded from state and counters.
- IDLE with start=1 and abort=0: latch mode and go to the first phase at the next edge. busy=1 and the first phase output is high in the cycle after the sampling edge.
- start while busy is ignored. start and abort together in IDLE: start is ignored.
- Pass = FILL (ctrl_fill, FILL_TICKS cycles) -> WASH -> DRAIN (ctrl_release, DRAIN_TICKS cycles).
- WASH pattern, repeating: forward DIR_TICKS, rest REST_TICKS, reverse DIR_TICKS, rest REST_TICKS. At WASH expiry go to DRAIN regardless of the sub-phase; the motor drops immediately.
- ctrl_forward and ctrl_reverse are never high together.
- Every direction change outside SPIN has at least REST_TICKS cycles with both motor lines off.
- Programs:
  - NORMAL: passes 0..NUM_RINSE, then SPIN.
  - QUICK: one pass with WASH_TICKS>>1, then SPIN.
  - RINSE_SPIN: NUM_RINSE passes, then SPIN. If NUM_RINSE=0, SPIN only.
  - SPIN_ONLY: DRAIN, then SPIN.
- SPIN: ctrl_release=1 and ctrl_forward=1 for SPIN_TICKS cycles. Then IDLE, with done=1 and busy=0 in that cycle.
- abort while busy and not in ABORT: the next cycle enters ABORT with ctrl_release=1 only, for DRAIN_TICKS cycles. Then IDLE with busy=0 and no done. abort during ABORT is ignored.
- pass_idx increments on each DRAIN->FILL transition and resets to 0 in IDLE.
- Each phase counter reloads on phase entry. A duration of 0 skips the phase (zero cycles).

Optional Feature:
PAUSE_EN.
- Defined: adds input port pause (1 bit). While pause=1 and busy=1, all counters freeze and all ctrl_* outputs are 0. phase and pass_idx hold. On release the program resumes at the frozen count. abort overrides pause. pause in IDLE has no effect.
- Undefined: no pause port; behaviour exactly as above.

Test Plan:
- Defaults, mode=0, start pulse 2 cycles: fill 8, wash 32, drain 8, ×2 passes, spin 16. done at cycle 112 after the sampling edge; pass_idx 0 then 1.
- mode=1: single pass with wash 16 cycles; done at cycle 48.
- abort asserted in pass 0 WASH cycle 10: motor off next cycle, ctrl_release for 8 cycles, busy=0, done never asserted.
- Every WASH cycle: forward and reverse never both high; exactly 2 zero cycles between each forward/reverse transition.
- rst_n low mid-SPIN: all outputs 0 asynchronously. After release, IDLE; a new start restarts at FILL with pass_idx=0.
- PAUSE_EN: pause for 20 cycles during FILL cycle 3: ctrl_fill=0 throughout; after release 5 more fill cycles; total completion shifted by exactly 20.
